// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: default geometry,
// default latencies, FSM state encoding and a counter-width helper.
package dmem_responder_pkg;

  // Default block-address width (depth = 2**DMEM_BLOCK_ADDR_SIZE blocks)
  localparam int DMEM_BLOCK_ADDR_SIZE = 4;
  // Default bits per block (must be a multiple of 8)
  localparam int DBLOCK_SIZE_BITS     = 64;
  // Default access latencies, in cycles from acceptance to response
  localparam int DMEM_READ_LATENCY    = 4;
  localparam int DMEM_WRITE_LATENCY   = 4;
  // Byte-lane width used by the storage array
  localparam int BYTE_W               = 8;

  // Responder FSM states
  typedef enum logic [1:0] {
    DMEM_IDLE       = 2'd0,
    DMEM_READ_WAIT  = 2'd1,
    DMEM_WRITE_WAIT = 2'd2,
    DMEM_RESP       = 2'd3
  } dmem_state_e;

  // Width of a down-counter able to hold max(rl, wl) - 1, never below 1 bit
  function automatic int lat_cnt_width(input int rl, input int wl);
    int m;
    m = (rl > wl) ? rl : wl;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/dmem_block_array.sv
// Synchronous single-port block storage for the data-memory responder.
// Split into independent byte lanes so optional byte enables map onto
// per-lane write enables; the read port is registered and resettable so
// the read data starts at zero. Storage contents are never reset.
module dmem_block_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_BLOCK_ADDR_SIZE,
  parameter int BLOCK_BITS = DBLOCK_SIZE_BITS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         we,
  input  logic                         re,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [BLOCK_BITS/BYTE_W-1:0] byte_en,
  input  logic [BLOCK_BITS-1:0]        wdata,
  output logic [BLOCK_BITS-1:0]        rdata
);

  localparam int NB    = BLOCK_BITS / BYTE_W;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [BYTE_W-1:0] lane_mem_q [DEPTH];
      logic [BYTE_W-1:0] lane_rd_q;

      // Commit this byte lane when a write is enabled for it
      always_ff @(posedge clock) begin
        if (we && byte_en[gi]) begin
          lane_mem_q[addr] <= wdata[gi*BYTE_W +: BYTE_W];
        end
      end

      // Registered read port; holds its value until the next read
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          lane_rd_q <= '0;
        end else if (re) begin
          lane_rd_q <= lane_mem_q[addr];
        end
      end

      assign rdata[gi*BYTE_W +: BYTE_W] = lane_rd_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Block-addressed data-memory responder for the D-cache refill/write-back
// path. Accepts one block read or write at a time, waits a fixed latency
// with a down-counter, then pulses ready (read) or done (write) for one
// cycle. Write wins when ren and wen arrive together.
// Optional feature: define DMEM_BYTE_MASK_EN to add a per-byte write mask
// input (wmask); without it every write replaces the whole block.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH    = DMEM_BLOCK_ADDR_SIZE,
  parameter int BLOCK_BITS    = DBLOCK_SIZE_BITS,
  parameter int READ_LATENCY  = DMEM_READ_LATENCY,
  parameter int WRITE_LATENCY = DMEM_WRITE_LATENCY
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ren,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        block_address,
  input  logic [BLOCK_BITS-1:0]        din,
`ifdef DMEM_BYTE_MASK_EN
  input  logic [BLOCK_BITS/BYTE_W-1:0] wmask,
`endif
  output logic [BLOCK_BITS-1:0]        dout,
  output logic                         ready,
  output logic                         done,
  output logic                         busy
);

  localparam int CNT_W = lat_cnt_width(READ_LATENCY, WRITE_LATENCY);
  localparam int NB    = BLOCK_BITS / BYTE_W;

  dmem_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BLOCK_BITS-1:0]   data_q, data_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    cnt_zero;
  logic                    mem_we;
  logic                    mem_re;
  logic [NB-1:0]           byte_en;

  assign cnt_zero = (cnt_q == '0);

  // State register; reset aborts whatever request is in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DMEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: write has priority over read in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMEM_IDLE: begin
        if (wen) begin
          state_d = DMEM_WRITE_WAIT;
        end else if (ren) begin
          state_d = DMEM_READ_WAIT;
        end
      end
      DMEM_READ_WAIT,
      DMEM_WRITE_WAIT: begin
        if (cnt_zero) begin
          state_d = DMEM_RESP;
        end
      end
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // Output/control decode: the array is accessed on the edge leaving a
  // WAIT state, and the matching pulse is registered for the RESP cycle
  always_comb begin
    mem_we  = (state_q == DMEM_WRITE_WAIT) && cnt_zero;
    mem_re  = (state_q == DMEM_READ_WAIT) && cnt_zero;
    ready_d = mem_re;
    done_d  = mem_we;
    busy_d  = (state_d != DMEM_IDLE);
  end

  // Request capture and latency countdown; inputs only matter in IDLE
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    if (state_q == DMEM_IDLE) begin
      if (wen) begin
        cnt_d  = CNT_W'(WRITE_LATENCY - 1);
        addr_d = block_address;
        data_d = din;
      end else if (ren) begin
        cnt_d  = CNT_W'(READ_LATENCY - 1);
        addr_d = block_address;
      end
    end else if ((state_q == DMEM_READ_WAIT || state_q == DMEM_WRITE_WAIT) && !cnt_zero) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter and latched request registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

`ifdef DMEM_BYTE_MASK_EN
  logic [NB-1:0] mask_q;

  // Byte mask is captured together with the write address and data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else if (state_q == DMEM_IDLE && wen) begin
      mask_q <= wmask;
    end
  end

  assign byte_en = mask_q;
`else
  assign byte_en = '1;
`endif

  // Registered response pulses and busy flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  dmem_block_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BLOCK_BITS (BLOCK_BITS)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .we      (mem_we),
    .re      (mem_re),
    .addr    (addr_q),
    .byte_en (byte_en),
    .wdata   (data_q),
    .rdata   (dout)
  );

  assign ready = ready_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by
// randomized traffic, all checked every cycle against a transaction-level
// model (acceptance edge + latency arithmetic over a shadow block array).
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int AW    = DMEM_BLOCK_ADDR_SIZE;
  localparam int BB    = DBLOCK_SIZE_BITS;
  localparam int NB    = BB / 8;
  localparam int RL    = DMEM_READ_LATENCY;
  localparam int WL    = DMEM_WRITE_LATENCY;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ren = 1'b0;
  logic          wen = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [BB-1:0] din = '0;
  logic [NB-1:0] wmask = '1;
  logic [BB-1:0] dout;
  logic          ready, done, busy;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clock         (clk),
    .reset         (rst),
    .ren           (ren),
    .wen           (wen),
    .block_address (addr),
    .din           (din),
`ifdef DMEM_BYTE_MASK_EN
    .wmask         (wmask),
`endif
    .dout          (dout),
    .ready         (ready),
    .done          (done),
    .busy          (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [BB-1:0] expand_mask(input logic [NB-1:0] m);
    logic [BB-1:0] e;
    for (int b = 0; b < NB; b++) e[b*8 +: 8] = {8{m[b]}};
    return e;
  endfunction

  function automatic logic [BB-1:0] rand_block();
    logic [BB-1:0] v;
    for (int i = 0; i < BB; i += 32) v[i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- transaction-level reference model ----------------
  logic [BB-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  bit            m_have = 0;
  bit            m_write = 0;
  int            m_addr = 0;
  int            m_e0 = 0;
  int            m_lat = 0;
  logic [BB-1:0] m_data = '0;
  logic [BB-1:0] m_mask = '0;
  logic [BB-1:0] m_dout = '0;
  bit            m_dout_known = 1;
  int            cyc = 0;

  always @(posedge rst) begin
    m_have = 0;
    m_dout = '0;
    m_dout_known = 1;
  end

  // cyc numbers the edge that just occurred; a request is accepted at an
  // edge when the preceding cycle was idle, completes L edges later, and
  // the responder is idle again in the cycle after the response.
  always @(posedge clk) begin
    bit idle_before;
    cyc++;
    if (rst) begin
      m_have = 0;
      m_dout = '0;
      m_dout_known = 1;
    end else begin
      idle_before = !m_have || (cyc - 1 > m_e0 + m_lat);
      if (m_have && cyc == m_e0 + m_lat) begin
        if (m_write) begin
          m_mem[m_addr]   = (m_mem[m_addr] & ~m_mask) | (m_data & m_mask);
          m_known[m_addr] = m_known[m_addr] | (&m_mask);
        end else begin
          m_dout       = m_mem[m_addr];
          m_dout_known = m_known[m_addr];
        end
      end
      if (idle_before && (wen || ren)) begin
        m_have  = 1;
        m_write = wen;
        m_addr  = int'(addr);
        m_e0    = cyc;
        m_lat   = wen ? WL : RL;
        m_data  = din;
`ifdef DMEM_BYTE_MASK_EN
        m_mask  = expand_mask(wmask);
`else
        m_mask  = '1;
`endif
      end
    end
  end

  // ---------------- per-cycle compare process ----------------
  int n_ready = 0;
  int n_done  = 0;

  always @(negedge clk) begin
    logic exp_busy, exp_ready, exp_done;
    exp_busy  = m_have && (cyc <= m_e0 + m_lat);
    exp_ready = m_have && !m_write && (cyc == m_e0 + m_lat);
    exp_done  = m_have && m_write && (cyc == m_e0 + m_lat);
    check("busy",  BB'(busy),  BB'(exp_busy));
    check("ready", BB'(ready), BB'(exp_ready));
    check("done",  BB'(done),  BB'(exp_done));
    if (m_dout_known) check("dout", dout, m_dout);
    if (ready) n_ready++;
    if (done)  n_done++;
  end

  // ---------------- driver ----------------
  int txn = 0;

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", BB'(busy), '0);
  endtask

  task automatic do_req(input bit w, input bit r, input int a, input logic [BB-1:0] d,
                        input logic [NB-1:0] m, input int hold, input int rst_after,
                        input bit scramble, output int lat_seen);
    @(negedge clk);
    wen = w; ren = r; addr = AW'(a); din = d; wmask = m;
    lat_seen = -1;
    if (rst_after > 0) begin
      repeat (rst_after) begin
        @(negedge clk);
        if (scramble) begin addr = AW'($urandom); din = rand_block(); end
      end
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0; wen = 1'b0; ren = 1'b0;
    end else begin
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (ready || done) begin
          lat_seen = k;
          break;
        end
        if (scramble) begin addr = AW'($urandom); din = rand_block(); end
      end
      if (lat_seen < 0) check("pulse_timeout", BB'(ready | done), BB'(1));
      repeat (hold) @(negedge clk);
      wen = 1'b0; ren = 1'b0;
    end
    wait_idle();
    txn++;
    $display("txn %0d: wen=%0b ren=%0b addr=%0d din=%0h mask=%0h hold=%0d rst_after=%0d pulse_at=%0d",
             txn, w, r, a, d, m, hold, rst_after, lat_seen);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, nr, nd;
    logic [BB-1:0] v5;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  BB'(busy),  '0);
    check("rst_ready", BB'(ready), '0);
    check("rst_done",  BB'(done),  '0);
    check("rst_dout",  dout,       '0);

    // give every block a known value
    for (int a = 0; a < DEPTH; a++) do_req(1, 0, a, rand_block(), '1, 0, 0, 0, lat);

    // write A5.. to block 3, read it back
    do_req(1, 0, 3, {NB{8'hA5}}, '1, 0, 0, 0, lat);
    check("wr_latency", BB'(lat), BB'(WL + 1));
    do_req(0, 1, 3, '0, '1, 0, 0, 0, lat);
    check("rd_latency", BB'(lat), BB'(RL + 1));
    check("rd3_dout",   dout,     {NB{8'hA5}});
    check("rd3_model",  m_dout,   {NB{8'hA5}});

    // ren and wen together: write wins
    nr = n_ready; nd = n_done;
    do_req(1, 1, 7, BB'(1), '1, 0, 0, 0, lat);
    check("both_done_cnt",  BB'(n_done - nd),  BB'(1));
    check("both_ready_cnt", BB'(n_ready - nr), BB'(0));
    do_req(0, 1, 7, '0, '1, 0, 0, 0, lat);
    check("rd7_dout", dout, BB'(1));

    // inputs changing during WRITE_WAIT have no effect
    v5 = rand_block();
    do_req(1, 0, 5, v5, '1, 0, 0, 1, lat);
    do_req(0, 1, 5, '0, '1, 0, 0, 0, lat);
    check("rd5_latched", dout, v5);

    // reset in WRITE_WAIT aborts the write
    do_req(1, 0, 2, {NB{8'h55}}, '1, 0, 0, 0, lat);
    nd = n_done;
    do_req(1, 0, 2, {NB{8'hAA}}, '1, 0, 2, 0, lat);
    check("abort_busy",     BB'(busy),        '0);
    check("abort_no_done",  BB'(n_done - nd), '0);
    do_req(0, 1, 2, '0, '1, 0, 0, 0, lat);
    check("rd2_after_abort", dout, {NB{8'h55}});

    // ren held into the IDLE cycle after ready: a second read is accepted
    nr = n_ready;
    do_req(0, 1, 3, '0, '1, 2, 0, 0, lat);
    check("hold_ready_cnt", BB'(n_ready - nr), BB'(2));

`ifdef DMEM_BYTE_MASK_EN
    do_req(1, 0, 0, {NB{8'hFF}}, '1, 0, 0, 0, lat);
    do_req(1, 0, 0, '0, NB'(1), 0, 0, 0, lat);
    do_req(0, 1, 0, '0, '1, 0, 0, 0, lat);
    check("mask_byte0", dout, {{(NB-1){8'hFF}}, 8'h00});
`endif

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      int op;
      bit w, r;
      op = int'($urandom_range(0, 3));
      w  = (op == 0) || (op == 1) || (op == 3);
      r  = (op == 2) || (op == 3);
      do_req(w, r, int'($urandom_range(0, DEPTH - 1)), rand_block(), NB'($urandom),
             ($urandom_range(0, 7) == 0) ? 2 : 0,
             ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0,
             bit'($urandom_range(0, 1)), lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
